// File: rtl/shift_req_sequencer.sv
// shift_req_sequencer
//   Request-side sequencer wrapped around an external combinational 32-bit
//   barrel left shifter. A single left shifter realises four operations:
//     SLL : direct left shift
//     SRL : reverse, left shift, reverse back
//     SRA : as SRL, then OR in the sign fill
//     ROL : left shift, then a second pass (the right-shift part) OR-ed in
//   Only one request is in flight. The result is held registered until it is
//   consumed.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   in_valid/ready    request handshake; in_data operand, in_amt amount,
//                     in_op 00 SLL / 01 SRL / 10 SRA / 11 ROL
//   sh_amt, sh_din    drive the shifter's amount and data inputs
//   sh_dout           shifter output (combinational, same cycle)
//   out_valid/ready   result handshake; out_data result
//   done_cnt          completed operations, wraps modulo 2^CNT_W
module shift_req_sequencer #(
  parameter int DATA_W = 32,
  parameter int AMT_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [AMT_W-1:0]  in_amt,
  input  logic [1:0]        in_op,
  output logic [AMT_W-1:0]  sh_amt,
  output logic [DATA_W-1:0] sh_din,
  input  logic [DATA_W-1:0] sh_dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  done_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    ROT2 = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  localparam logic [AMT_W-1:0] AMT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [AMT_W-1:0]  ramt_q,  ramt_d;
  logic [1:0]        rop_q,   rop_d;
  logic [DATA_W-1:0] acc_q,   acc_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  function automatic logic [DATA_W-1:0] rev(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) begin
      r[i] = x[DATA_W-1-i];
    end
    return r;
  endfunction

  // Sign fill for SRA: the top ramt bits set when the operand is negative.
  // With ramt = 0 the mask is empty, so SRA by 0 returns the operand.
  function automatic logic [DATA_W-1:0] sra_fill(input logic              sign,
                                                 input logic [AMT_W-1:0]  amt);
    logic [DATA_W-1:0] ones;
    ones = '1;
    return sign ? ~(ones >> amt) : '0;
  endfunction

  always_comb begin
    state_d  = state_q;
    rdata_d  = rdata_q;
    ramt_d   = ramt_q;
    rop_d    = rop_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    in_ready = 1'b0;
    sh_amt   = '0;
    sh_din   = '0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          rdata_d = in_data;
          ramt_d  = in_amt;
          rop_d   = in_op;
          state_d = EXEC;
        end
      end

      EXEC: begin
        sh_amt = ramt_q;
        // Right shifts go through the left shifter on the reversed operand.
        sh_din = (rop_q == OP_SRL || rop_q == OP_SRA) ? rev(rdata_q) : rdata_q;
        unique case (rop_q)
          OP_SLL:  acc_d = sh_dout;
          OP_SRL:  acc_d = rev(sh_dout);
          OP_SRA:  acc_d = rev(sh_dout) | sra_fill(rdata_q[DATA_W-1], ramt_q);
          default: acc_d = sh_dout;
        endcase
        state_d = (rop_q == OP_ROL && ramt_q != '0) ? ROT2 : DONE;
      end

      ROT2: begin
        // Bits rotated out of the top re-enter at the bottom:
        // rdata >> (DATA_W - ramt), built as rev(rev(rdata) << (DATA_W - ramt)).
        // The two's complement of ramt is DATA_W - ramt modulo DATA_W.
        sh_amt  = ~ramt_q + AMT_ONE;
        sh_din  = rev(rdata_q);
        acc_d   = acc_q | rev(sh_dout);
        state_d = DONE;
      end

      DONE: begin
        if (out_ready) begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request registers only matter once a request is accepted, so no reset.
  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    ramt_q  <= ramt_d;
    rop_q   <= rop_d;
  end

  assign out_valid = (state_q == DONE);
  assign out_data  = acc_q;
  assign done_cnt  = cnt_q;

endmodule

// File: tb/tb_shift_req_sequencer.sv
module tb_shift_req_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_amt;
  logic [1:0]  in_op;
  logic [4:0]  sh_amt;
  logic [31:0] sh_din;
  logic [31:0] sh_dout;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] done_cnt;

  int          vectors    = 0;
  int          miscompares = 0;
  logic [15:0] exp_cnt    = '0;

  always #5 clk = ~clk;

  // Behavioural model of the external combinational left shifter.
  assign sh_dout = sh_din << sh_amt;

  shift_req_sequencer #(.DATA_W(32), .AMT_W(5), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .sh_amt    (sh_amt),
    .sh_din    (sh_din),
    .sh_dout   (sh_dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .done_cnt  (done_cnt)
  );

  // Reference result from the operation's arithmetic definition.
  function automatic logic [31:0] golden(input logic [31:0] d, input logic [4:0] a,
                                         input logic [1:0] op);
    logic [63:0] dd;
    logic signed [31:0] sd;
    dd = {d, d} << a;
    sd = d;
    case (op)
      2'b00:   return d << a;
      2'b01:   return d >> a;
      2'b10:   return sd >>> a;
      default: return dd[63:32];
    endcase
  endfunction

  // Issue one request and wait for its result. lat counts clock edges from the
  // accepting edge (inclusive) to the edge after which out_valid is seen; -1 on
  // timeout. When out_ready is high the result is also consumed.
  task automatic send(input logic [31:0] d, input logic [4:0] a, input logic [1:0] op,
                      output logic [31:0] got, output int lat);
    int guard;
    guard    = 0;
    in_data  = d;
    in_amt   = a;
    in_op    = op;
    in_valid = 1'b1;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    got = out_data;
    if (out_ready && out_valid) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_cnt = '0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0 ||
        done_cnt !== 16'h0 || sh_amt !== 5'h0 || sh_din !== 32'h0) begin
      miscompares++;
      $display("FAIL reset: in_ready=%b out_valid=%b out_data=%h done_cnt=%0d sh_amt=%0d sh_din=%h, want 1 0 0 0 0 0",
               in_ready, out_valid, out_data, done_cnt, sh_amt, sh_din);
    end
  endtask

  task automatic test_sll();
    logic [31:0] got;
    int lat;
    out_ready = 1'b1;
    send(32'h0000_0001, 5'd31, 2'b00, got, lat);
    exp_cnt++;
    vectors++;
    if (got !== 32'h8000_0000 || lat !== 2) begin
      miscompares++;
      $display("FAIL sll: data=%h lat=%0d, want 80000000 lat 2", got, lat);
    end
    vectors++;
    if (done_cnt !== exp_cnt) begin
      miscompares++;
      $display("FAIL sll_cnt: done_cnt=%0d, want %0d", done_cnt, exp_cnt);
    end
  endtask

  task automatic test_right_shifts();
    logic [31:0] got;
    int lat;
    out_ready = 1'b1;
    send(32'h8000_00F0, 5'd4, 2'b10, got, lat);
    exp_cnt++;
    vectors++;
    if (got !== 32'hF800_000F || lat !== 2) begin
      miscompares++;
      $display("FAIL sra: data=%h lat=%0d, want f800000f lat 2", got, lat);
    end
    send(32'h8000_00F0, 5'd4, 2'b01, got, lat);
    exp_cnt++;
    vectors++;
    if (got !== 32'h0800_000F || lat !== 2) begin
      miscompares++;
      $display("FAIL srl: data=%h lat=%0d, want 0800000f lat 2", got, lat);
    end
  endtask

  task automatic test_rol();
    logic [31:0] got;
    int lat;
    out_ready = 1'b1;
    send(32'h8000_0001, 5'd1, 2'b11, got, lat);
    exp_cnt++;
    vectors++;
    if (got !== 32'h0000_0003 || lat !== 3) begin
      miscompares++;
      $display("FAIL rol1: data=%h lat=%0d, want 00000003 lat 3", got, lat);
    end
    send(32'h8000_0001, 5'd0, 2'b11, got, lat);
    exp_cnt++;
    vectors++;
    if (got !== 32'h8000_0001 || lat !== 2) begin
      miscompares++;
      $display("FAIL rol0: data=%h lat=%0d, want 80000001 lat 2", got, lat);
    end
  endtask

  task automatic test_amt_zero();
    logic [31:0] got, d;
    int lat;
    out_ready = 1'b1;
    for (int op = 0; op < 4; op++) begin
      d = $urandom | 32'h8000_0000;
      send(d, 5'd0, op[1:0], got, lat);
      exp_cnt++;
      vectors++;
      if (got !== d) begin
        miscompares++;
        $display("FAIL amt0_op%0d: data=%h, want %h", op, got, d);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] got, d;
    int lat;
    d = 32'h1234_5678;
    out_ready = 1'b0;
    send(d, 5'd8, 2'b00, got, lat);
    // A competing request stays presented while the result is stalled.
    in_data  = 32'hDEAD_BEEF;
    in_amt   = 5'd3;
    in_op    = 2'b01;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 32'h3456_7800 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL backpressure_c%0d: out_valid=%b out_data=%h in_ready=%b, want 1 34567800 0",
                 i, out_valid, out_data, in_ready);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    exp_cnt++;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || done_cnt !== exp_cnt) begin
      miscompares++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b done_cnt=%0d, want 0 1 %0d",
               out_valid, in_ready, done_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got;
    int lat;
    // Reset while in EXEC.
    out_ready = 1'b1;
    in_data = 32'hA5A5_0001; in_amt = 5'd3; in_op = 2'b11; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = '0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || done_cnt !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_exec: out_valid=%b in_ready=%b done_cnt=%0d, want 0 1 0",
               out_valid, in_ready, done_cnt);
    end
    // Reset while in DONE.
    out_ready = 1'b0;
    send(32'h0F0F_0F0F, 5'd2, 2'b01, got, lat);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || done_cnt !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_done: out_valid=%b in_ready=%b done_cnt=%0d, want 0 1 0",
               out_valid, in_ready, done_cnt);
    end
    send(32'h0000_0003, 5'd5, 2'b00, got, lat);
    exp_cnt++;
    vectors++;
    if (got !== 32'h0000_0060 || done_cnt !== exp_cnt) begin
      miscompares++;
      $display("FAIL reset_fresh: data=%h done_cnt=%0d, want 00000060 %0d", got, done_cnt, exp_cnt);
    end
  endtask

  task automatic test_random();
    logic [31:0] expq[$];
    logic [31:0] d;
    logic [4:0]  a;
    logic [1:0]  op;
    logic        acc_fire, out_fire;
    int          accepted, cycles;
    accepted = 0;
    cycles   = 0;
    while ((accepted < 10000 || expq.size() != 0) && cycles < 80000) begin
      if (accepted < 10000) begin
        d  = $urandom;
        a  = ($urandom_range(0, 7) == 0) ? 5'(($urandom_range(0, 1) != 0) ? 31 : 0)
                                         : 5'($urandom_range(0, 31));
        op = 2'($urandom_range(0, 3));
        in_data  = d;
        in_amt   = a;
        in_op    = op;
        in_valid = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      acc_fire  = in_valid && in_ready;
      out_fire  = out_valid && out_ready;
      if (out_fire) begin
        vectors++;
        if (expq.size() == 0) begin
          miscompares++;
          $display("FAIL rand_unexpected: out_data=%h with no request outstanding", out_data);
        end else if (out_data !== expq[0]) begin
          miscompares++;
          $display("FAIL rand_data: out_data=%h, want %h", out_data, expq[0]);
          void'(expq.pop_front());
        end else begin
          void'(expq.pop_front());
        end
        exp_cnt++;
      end
      if (acc_fire) begin
        expq.push_back(golden(d, a, op));
        accepted++;
        if (expq.size() > 1) begin
          miscompares++;
          $display("FAIL rand_overlap: %0d requests outstanding, want at most 1", expq.size());
        end
      end
      @(posedge clk); #1;
      cycles++;
    end
    in_valid = 1'b0;
    vectors++;
    if (cycles >= 80000) begin
      miscompares++;
      $display("FAIL rand_timeout: accepted=%0d outstanding=%0d, want 10000 0", accepted, expq.size());
    end
    vectors++;
    if (done_cnt !== exp_cnt) begin
      miscompares++;
      $display("FAIL rand_cnt: done_cnt=%0d, want %0d", done_cnt, exp_cnt);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_op     = '0;
    out_ready = 1'b0;
    test_reset();
    test_sll();
    test_right_shifts();
    test_rol();
    test_amt_zero();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
